// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI-attached RAM controller: command opcodes carried
// in the top bits of each deserialised word, and the protocol FSM states.
package spi_ram_pkg;

  localparam int OPC_W = 2;

  typedef enum logic [OPC_W-1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_WR_ARMED   = 2'b01,
    ST_RD_ARMED   = 2'b10,
    ST_BOTH_ARMED = 2'b11
  } proto_state_e;

endpackage

// File: rtl/ram_sp_array.sv
// Storage array with one write port and a registered, enabled read port.
// The read register only updates on a read request, so it holds otherwise.
module ram_sp_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Write port.
  // NOTE: the array has no reset branch; clearing every word would turn the
  // memory into a huge register file, and callers never rely on its contents.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read; reads the array state left by earlier writes.
  // NOTE: non-blocking assignment keeps all flops updating from the values
  // sampled at the same edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram_ctrl_p.sv
// Command decoder for the SPI-attached RAM. Tracks write/read addresses,
// flags data commands issued before their address has been armed, and
// returns read data to the serialiser through a valid-tagged pipeline.
module spi_ram_ctrl_p
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter bit AUTO_INC = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W+OPC_W-1:0] din,
  input  logic                    rx_valid,
  output logic [DATA_W-1:0]       dout,
  output logic                    tx_valid,
  output logic                    err
);

  cmd_e              w_cmd;
  logic [DATA_W-1:0] w_payload;
  logic [ADDR_W-1:0] w_addr_pl;
  logic              w_wr_addr_cmd, w_wr_data_cmd, w_rd_addr_cmd, w_rd_data_cmd;
  logic              w_err_set;
  logic [DATA_W-1:0] w_ram_q;
  proto_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
  logic              r_err;
  logic              r_vld_ram, r_vld1;
  logic [DATA_W-1:0] r_dout1;

  assign w_cmd         = cmd_e'(din[DATA_W+OPC_W-1:DATA_W]);
  assign w_payload     = din[DATA_W-1:0];
  assign w_addr_pl     = w_payload[ADDR_W-1:0];
  assign w_wr_addr_cmd = rx_valid && (w_cmd == CMD_WR_ADDR);
  assign w_wr_data_cmd = rx_valid && (w_cmd == CMD_WR_DATA);
  assign w_rd_addr_cmd = rx_valid && (w_cmd == CMD_RD_ADDR);
  assign w_rd_data_cmd = rx_valid && (w_cmd == CMD_RD_DATA);

  // Protocol state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and error detection for data commands issued before arming.
  // NOTE: every output gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    if (rx_valid) begin
      case (w_cmd)
        CMD_WR_ADDR: begin
          if (r_state == ST_IDLE)          w_state_nxt = ST_WR_ARMED;
          else if (r_state == ST_RD_ARMED) w_state_nxt = ST_BOTH_ARMED;
        end
        CMD_RD_ADDR: begin
          if (r_state == ST_IDLE)          w_state_nxt = ST_RD_ARMED;
          else if (r_state == ST_WR_ARMED) w_state_nxt = ST_BOTH_ARMED;
        end
        CMD_WR_DATA: w_err_set = (r_state == ST_IDLE) || (r_state == ST_RD_ARMED);
        CMD_RD_DATA: w_err_set = (r_state == ST_IDLE) || (r_state == ST_WR_ARMED);
        default: ;
      endcase
    end
  end

  // Address registers (optionally post-incremented, wrapping) and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_wr_addr_cmd)                 r_wr_addr <= w_addr_pl;
      else if (w_wr_data_cmd && AUTO_INC) r_wr_addr <= r_wr_addr + 1'b1;
      if (w_rd_addr_cmd)                 r_rd_addr <= w_addr_pl;
      else if (w_rd_data_cmd && AUTO_INC) r_rd_addr <= r_rd_addr + 1'b1;
      if (w_err_set)                     r_err     <= 1'b1;
    end
  end

  ram_sp_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_data_cmd),
    .i_waddr (r_wr_addr),
    .i_wdata (w_payload),
    .i_re    (w_rd_data_cmd),
    .i_raddr (r_rd_addr),
    .o_rdata (w_ram_q)
  );

  // Valid tags follow each read through the RAM register and first output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_ram <= 1'b0;
      r_vld1    <= 1'b0;
      r_dout1   <= '0;
    end else begin
      r_vld_ram <= w_rd_data_cmd;
      r_vld1    <= r_vld_ram;
      if (r_vld_ram) r_dout1 <= w_ram_q;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              r_vld2;
    logic [DATA_W-1:0] r_dout2;

    // Extra output stage for the two-cycle latency build.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld2  <= 1'b0;
        r_dout2 <= '0;
      end else begin
        r_vld2 <= r_vld1;
        if (r_vld1) r_dout2 <= r_dout1;
      end
    end

    assign dout     = r_dout2;
    assign tx_valid = r_vld2;
  end else begin : g_lat1
    assign dout     = r_dout1;
    assign tx_valid = r_vld1;
  end

  assign err = r_err;

endmodule
